// File: rtl/mont_red_iter.sv
// Word-serial Montgomery reduction: out_t = in_t * 2^(-W*N_ITER) mod q,
// with q = 2^(K_BASE+current_k) - q_m*2^W + 1, one W-bit word per cycle.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready only while idle)
//   in_t, q_m,           operand T, modulus parameter,
//   current_k, lazy      modulus select, skip final subtraction
//   out_valid/out_ready  result handshake (result held until taken)
//   out_t, out_err       result, illegal current_k flag
module mont_red_iter #(
    parameter int W      = 24,
    parameter int M      = 17,
    parameter int K_BASE = 46,
    parameter int K_SPAN = 8,
    parameter int N_ITER = 3,
    localparam int QW    = K_BASE + K_SPAN,
    parameter int TW     = 2 * QW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [TW-1:0] in_t,
    input  logic [M-1:0]  q_m,
    input  logic [3:0]    current_k,
    input  logic          lazy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW:0]   out_t,
    output logic          out_err
);

    // Working width for T: holds the raw operand and every partial sum
    // T + m*q without truncation; one extra bit for the adder carry.
    localparam int TR = ((TW > W + QW + 1) ? TW : W + QW + 1) + 1;
    localparam int SW = TR + 1;
    localparam int CW = $clog2(N_ITER + 1);

    if (W * N_ITER <= QW) begin : g_chk_iter
        $error("mont_red_iter: W*N_ITER must exceed QW");
    end
    // q must stay congruent to 1 mod 2^W so that m = -T mod 2^W
    // clears the low word, and q_m*2^W must stay below 2^K_BASE.
    if (M + W > K_BASE) begin : g_chk_qm
        $error("mont_red_iter: q_m*2^W must fit below 2^K_BASE");
    end
    if (K_SPAN > 15) begin : g_chk_span
        $error("mont_red_iter: K_SPAN must fit current_k");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_CORR = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [TR-1:0] t_r;
    logic [M-1:0]  qm_r;
    logic [3:0]    k_r;
    logic          lazy_r;
    logic [CW-1:0] cnt;
    logic [QW:0]   out_t_r;
    logic          out_err_r;

    logic [QW:0]     q_pow;
    logic [QW:0]     q_sub;
    logic [QW:0]     q;
    logic [W-1:0]    m;
    logic [W+QW:0]   mq;
    logic [SW-1:0]   sum;
    logic [TR-1:0]   t_next;
    logic            illegal;
    logic            ge;
    logic [QW:0]     diff;

    // Modulus from the latched operands; for an illegal k the shifted
    // power may fall off the top, which is harmless as q is unused then.
    assign q_pow = (QW+1)'(1) << (K_BASE + int'(k_r));
    assign q_sub = {{(QW + 1 - M - W){1'b0}}, qm_r, {W{1'b0}}};
    assign q     = q_pow - q_sub + (QW+1)'(1);

    // Since q = 1 mod 2^W, adding m*q with m = -T mod 2^W zeroes the
    // low word and the shift below is an exact division.
    assign m      = W'(0) - t_r[W-1:0];
    assign mq     = {{(QW + 1){1'b0}}, m} * {{W{1'b0}}, q};
    assign sum    = {1'b0, t_r} + SW'(mq);
    assign t_next = TR'(sum >> W);

    assign illegal = k_r > 4'(K_SPAN);
    assign ge      = t_r >= TR'(q);
    // T < 2q here, so T - q < q fits the result width exactly.
    assign diff    = t_r[QW:0] - q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            t_r       <= '0;
            qm_r      <= '0;
            k_r       <= '0;
            lazy_r    <= 1'b0;
            cnt       <= '0;
            out_t_r   <= '0;
            out_err_r <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        t_r    <= TR'(in_t);
                        qm_r   <= q_m;
                        k_r    <= current_k;
                        lazy_r <= lazy;
                        cnt    <= '0;
                        state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (!illegal) begin
                        t_r <= t_next;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N_ITER - 1)) begin
                        state <= S_CORR;
                    end
                end
                S_CORR: begin
                    out_err_r <= illegal;
                    if (illegal) begin
                        out_t_r <= '0;
                    end else if (ge && !lazy_r) begin
                        out_t_r <= diff;
                    end else begin
                        out_t_r <= t_r[QW:0];
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Both handshake outputs decode the registered state only, so
    // out_ready never reaches in_ready combinationally.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_t     = out_t_r;
    assign out_err   = out_err_r;

endmodule

// File: doc/mont_red_iter.md
MONT_RED_ITER -- requirements
Module: mont_red_iter

Interface
REQ-001 SHALL have parameter W, default 24, reduction word size in bits.
REQ-002 SHALL have parameter M, default 17, bit-size of q_m.
REQ-003 SHALL have parameter K_BASE, default 46, modulus exponent for current_k = 0.
REQ-004 SHALL have parameter K_SPAN, default 8, largest legal current_k; modulus width QW = K_BASE+K_SPAN, default 54.
REQ-005 SHALL have parameter N_ITER, default 3, number of word iterations; W*N_ITER SHALL exceed QW, checked at elaboration.
REQ-006 SHALL have parameter TW, default 2*QW, input width.
REQ-007 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1, input transaction offered.
REQ-010 SHALL have port in_ready, output, 1, block can accept a transaction.
REQ-011 SHALL have port in_t, input, TW, operand T.
REQ-012 SHALL have port q_m, input, M, modulus parameter.
REQ-013 SHALL have port current_k, input, 4, modulus select; q = 2^(K_BASE+current_k) - q_m*2^W + 1.
REQ-014 SHALL have port lazy, input, 1, when 1 the final conditional subtraction is skipped.
REQ-015 SHALL have port out_valid, output, 1, result held and valid.
REQ-016 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-017 SHALL have port out_t, output, QW+1, result.
REQ-018 SHALL have port out_err, output, 1, current_k was illegal for this result.

Function
REQ-019 SHALL implement FSM IDLE -> ITER -> CORR -> DONE -> IDLE; in_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a transaction on in_valid && in_ready and latch in_t, q_m, current_k and lazy; later input changes SHALL have no effect on that transaction.
REQ-021 SHALL perform, in ITER, exactly one iteration per cycle for N_ITER cycles: m = (-T) mod 2^W, T <= (T + m*q) >> W; the division SHALL be exact.
REQ-022 SHALL hold the intermediate T in a register of at least QW+2 bits; no intermediate truncation is allowed when in_t < q*2^(W*N_ITER).
REQ-023 SHALL, in CORR, compute out_t = T-q if T >= q and lazy = 0, otherwise out_t = T.
REQ-024 SHALL assert out_valid in DONE; the latency from the acceptance edge to the first out_valid cycle SHALL be exactly N_ITER+2 cycles.
REQ-025 SHALL hold out_t, out_err and out_valid stable while out_valid && !out_ready, for unlimited cycles.
REQ-026 SHALL return to IDLE on the edge where out_valid && out_ready; in_ready SHALL rise in the next cycle, with no combinational path from out_ready to in_ready.
REQ-027 SHALL, for current_k > K_SPAN, skip the iterations, keep the same N_ITER+2 latency, and output out_t = 0 with out_err = 1.
REQ-028 SHALL produce out_t = T*2^(-W*N_ITER) mod q in [0,q) when lazy = 0, and a congruent value in [0,2q) when lazy = 1.
REQ-029 SHALL treat in_t >= q*2^(W*N_ITER) as outside the contract; the output for such operands is unspecified but the FSM SHALL still complete the transaction.

Reset
REQ-030 SHALL, with rst high at an edge, set the FSM to IDLE, out_valid = 0, out_err = 0, out_t = 0 and in_ready = 1 from the next cycle, from any state.
REQ-031 SHALL discard an in-flight transaction on reset and produce no output for it.
REQ-032 SHALL take precedence of rst over in_valid in the same cycle; that transaction is not accepted.

Verification
REQ-033 SHALL cover: current_k = 0, q_m = 0 (q = 2^46+1), in_t = 2^72*5, lazy = 0 -> out_t = 5, out_err = 0, out_valid exactly 5 cycles after acceptance.
REQ-034 SHALL cover: in_t = q (same q) -> out_t = 0; in_t = 0 -> out_t = 0.
REQ-035 SHALL cover: current_k = 8, q_m = 2^17-1, 10,000 random legal in_t with lazy in {0,1} -> each result matches the model of REQ-028.
REQ-036 SHALL cover: out_ready held low for 20 cycles -> out_t stable, in_ready = 0 throughout; after out_ready rises, in_ready = 1 on the following cycle.
REQ-037 SHALL cover: current_k = 12 -> out_t = 0, out_err = 1, latency 5 cycles.
REQ-038 SHALL cover: rst asserted in the second ITER cycle -> out_valid never rises for that transaction, and in_ready = 1 on the cycle after reset is released.
